cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_pkg.sv | 48 ++++
 rtl/cpu_ctrl_decode.sv | 78 +++++++
 rtl/cpu_sequencer.sv | 95 +++++++++
 tb/tb_cpu_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU: sequencer states, opcode map and control word layout.
package cpu_pkg;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec1  = 3'd2,
        StExec2  = 3'd3,
        StHalt   = 3'd4
    } state_e;

    localparam logic [3:0] OpNop = 4'h0;
    localparam logic [3:0] OpLda = 4'h1;
    localparam logic [3:0] OpLdb = 4'h2;
    localparam logic [3:0] OpAdd = 4'h3;
    localparam logic [3:0] OpSub = 4'h4;
    localparam logic [3:0] OpLdm = 4'h5;
    localparam logic [3:0] OpStm = 4'h6;
    localparam logic [3:0] OpJmp = 4'h7;
    localparam logic [3:0] OpJz  = 4'h8;
    localparam logic [3:0] OpJc  = 4'h9;
    localparam logic [3:0] OpHlt = 4'hF;

    localparam int unsigned CtrlWidth = 14;

    typedef struct packed {
        logic halted;
        logic ir_load;
        logic pc_inc;
        logic pc_load;
        logic imm;
        logic a;
        logic b;
        logic a_out;
        logic alu_out;
        logic alu_sub;
        logic flags_load;
        logic mar_load;
        logic mem_out;
        logic mem_we;
    } ctrl_t;

    // Memory ops are the only ones needing a second execute cycle.
    function automatic logic is_two_step(input logic [3:0] op);
        return (op == OpLdm) || (op == OpStm);
    endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational control-word decode from sequencer state, opcode and flags.
module cpu_ctrl_decode
    import cpu_pkg::*;
(
    input  logic [2:0]           i_state,
    input  logic [3:0]           i_opcode,
    input  logic                 i_flag_z,
    input  logic                 i_flag_c,
    input  logic                 i_fetch_go,
    output logic [CtrlWidth-1:0] o_ctrl
);

    ctrl_t w_ctrl;

    // Decode one control word per cycle; anything unlisted drives nothing.
    always_comb begin
        w_ctrl = '0;
        case (i_state)
            StFetch: begin
                if (i_fetch_go) begin
                    w_ctrl.ir_load = 1'b1;
                    w_ctrl.pc_inc  = 1'b1;
                end
            end
            StExec1: begin
                case (i_opcode)
                    OpLda: begin
                        w_ctrl.imm = 1'b1;
                        w_ctrl.a   = 1'b1;
                    end
                    OpLdb: begin
                        w_ctrl.imm = 1'b1;
                        w_ctrl.b   = 1'b1;
                    end
                    OpAdd, OpSub: begin
                        w_ctrl.alu_out    = 1'b1;
                        w_ctrl.a          = 1'b1;
                        w_ctrl.flags_load = 1'b1;
                        w_ctrl.alu_sub    = (i_opcode == OpSub);
                    end
                    OpLdm, OpStm: begin
                        w_ctrl.imm      = 1'b1;
                        w_ctrl.mar_load = 1'b1;
                    end
                    OpJmp: begin
                        w_ctrl.imm     = 1'b1;
                        w_ctrl.pc_load = 1'b1;
                    end
                    OpJz: begin
                        w_ctrl.imm     = i_flag_z;
                        w_ctrl.pc_load = i_flag_z;
                    end
                    OpJc: begin
                        w_ctrl.imm     = i_flag_c;
                        w_ctrl.pc_load = i_flag_c;
                    end
                    default: ;
                endcase
            end
            StExec2: begin
                if (i_opcode == OpLdm) begin
                    w_ctrl.mem_out = 1'b1;
                    w_ctrl.a       = 1'b1;
                end else if (i_opcode == OpStm) begin
                    w_ctrl.a_out  = 1'b1;
                    w_ctrl.mem_we = 1'b1;
                end
            end
            StHalt: begin
                w_ctrl.halted = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_ctrl = w_ctrl;

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: state register and next-state logic; outputs come from cpu_ctrl_decode.
module cpu_sequencer
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] c_opcode,
    input  logic       flag_z,
    input  logic       flag_c,
    input  logic       run,
    input  logic       imem_ready,
    output logic       c_ir_load,
    output logic       c_pc_inc,
    output logic       c_pc_load,
    output logic       c_imm,
    output logic       c_a,
    output logic       c_b,
    output logic       c_a_out,
    output logic       c_alu_out,
    output logic       c_alu_sub,
    output logic       c_flags_load,
    output logic       c_mar_load,
    output logic       c_mem_out,
    output logic       c_mem_we,
    output logic       halted
);

    state_e               r_state;
    state_e               w_state_next;
    logic                 w_fetch_go;
    logic [CtrlWidth-1:0] w_ctrl_bits;
    ctrl_t                w_ctrl;

    assign w_fetch_go = run & imem_ready;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: fetch waits on run/ready, memory ops take EXEC2, HLT parks in HALT.
    always_comb begin
        w_state_next = StFetch;
        case (r_state)
            StFetch:  w_state_next = w_fetch_go ? StDecode : StFetch;
            StDecode: w_state_next = StExec1;
            StExec1: begin
                if (is_two_step(c_opcode)) begin
                    w_state_next = StExec2;
                end else if (c_opcode == OpHlt) begin
                    w_state_next = StHalt;
                end else begin
                    w_state_next = StFetch;
                end
            end
            StExec2:  w_state_next = StFetch;
            StHalt:   w_state_next = StHalt;
            default:  w_state_next = StFetch;
        endcase
    end

    cpu_ctrl_decode u_decode (
        .i_state    (r_state),
        .i_opcode   (c_opcode),
        .i_flag_z   (flag_z),
        .i_flag_c   (flag_c),
        .i_fetch_go (w_fetch_go),
        .o_ctrl     (w_ctrl_bits)
    );

    // Reset blanks every output in the cycle it is sampled, whatever the state.
    always_comb begin
        w_ctrl = reset ? '0 : ctrl_t'(w_ctrl_bits);
    end

    assign halted       = w_ctrl.halted;
    assign c_ir_load    = w_ctrl.ir_load;
    assign c_pc_inc     = w_ctrl.pc_inc;
    assign c_pc_load    = w_ctrl.pc_load;
    assign c_imm        = w_ctrl.imm;
    assign c_a          = w_ctrl.a;
    assign c_b          = w_ctrl.b;
    assign c_a_out      = w_ctrl.a_out;
    assign c_alu_out    = w_ctrl.alu_out;
    assign c_alu_sub    = w_ctrl.alu_sub;
    assign c_flags_load = w_ctrl.flags_load;
    assign c_mar_load   = w_ctrl.mar_load;
    assign c_mem_out    = w_ctrl.mem_out;
    assign c_mem_we     = w_ctrl.mem_we;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: stimulus pushes per-cycle expected control words,
// a negedge monitor pops and compares them and checks bus-driver exclusivity.
module tb_cpu_sequencer;

    localparam logic [13:0] MH   = 14'h2000;
    localparam logic [13:0] MIR  = 14'h1000;
    localparam logic [13:0] MPCI = 14'h0800;
    localparam logic [13:0] MPCL = 14'h0400;
    localparam logic [13:0] MIMM = 14'h0200;
    localparam logic [13:0] MA   = 14'h0100;
    localparam logic [13:0] MB   = 14'h0080;
    localparam logic [13:0] MAO  = 14'h0040;
    localparam logic [13:0] MALU = 14'h0020;
    localparam logic [13:0] MSUB = 14'h0010;
    localparam logic [13:0] MFL  = 14'h0008;
    localparam logic [13:0] MMAR = 14'h0004;
    localparam logic [13:0] MMO  = 14'h0002;
    localparam logic [13:0] MWE  = 14'h0001;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] c_opcode = 4'h0;
    logic       flag_z = 1'b0;
    logic       flag_c = 1'b0;
    logic       run = 1'b0;
    logic       imem_ready = 1'b0;
    logic       c_ir_load, c_pc_inc, c_pc_load, c_imm, c_a, c_b, c_a_out;
    logic       c_alu_out, c_alu_sub, c_flags_load, c_mar_load, c_mem_out, c_mem_we, halted;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;

    logic [13:0] sb_exp[$];
    string       sb_tag[$];

    cpu_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .c_opcode     (c_opcode),
        .flag_z       (flag_z),
        .flag_c       (flag_c),
        .run          (run),
        .imem_ready   (imem_ready),
        .c_ir_load    (c_ir_load),
        .c_pc_inc     (c_pc_inc),
        .c_pc_load    (c_pc_load),
        .c_imm        (c_imm),
        .c_a          (c_a),
        .c_b          (c_b),
        .c_a_out      (c_a_out),
        .c_alu_out    (c_alu_out),
        .c_alu_sub    (c_alu_sub),
        .c_flags_load (c_flags_load),
        .c_mar_load   (c_mar_load),
        .c_mem_out    (c_mem_out),
        .c_mem_we     (c_mem_we),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Hand-derived EXEC1 control word per opcode.
    function automatic logic [13:0] exp_e1(input logic [3:0] op, input logic z, input logic c);
        case (op)
            4'h1:       return MIMM | MA;
            4'h2:       return MIMM | MB;
            4'h3:       return MALU | MA | MFL;
            4'h4:       return MALU | MA | MFL | MSUB;
            4'h5, 4'h6: return MIMM | MMAR;
            4'h7:       return MIMM | MPCL;
            4'h8:       return z ? (MIMM | MPCL) : 14'h0;
            4'h9:       return c ? (MIMM | MPCL) : 14'h0;
            default:    return 14'h0;
        endcase
    endfunction

    // One cycle: drive inputs just after the edge and queue what the DUT must show this cycle.
    task automatic tick(input logic rst, input logic rn, input logic rdy, input logic [3:0] op,
                        input logic z, input logic c, input logic [13:0] exp, input string tag);
        @(posedge clk);
        #1;
        reset      = rst;
        run        = rn;
        imem_ready = rdy;
        c_opcode   = op;
        flag_z     = z;
        flag_c     = c;
        sb_exp.push_back(exp);
        sb_tag.push_back(tag);
    endtask

    // Full instruction from FETCH with zero wait states; run drops after the fetch cycle.
    task automatic instr(input logic [3:0] op, input logic z, input logic c, input string tag);
        tick(1'b0, 1'b1, 1'b1, op, z, c, MIR | MPCI, {tag, "_fetch"});
        tick(1'b0, 1'b0, 1'b0, op, z, c, 14'h0, {tag, "_decode"});
        tick(1'b0, 1'b0, 1'b0, op, z, c, exp_e1(op, z, c), {tag, "_exec1"});
        if (op == 4'h5) tick(1'b0, 1'b0, 1'b0, op, z, c, MMO | MA, {tag, "_exec2"});
        if (op == 4'h6) tick(1'b0, 1'b0, 1'b0, op, z, c, MAO | MWE, {tag, "_exec2"});
    endtask

    // Monitor: compare queued expectation and bus-driver exclusivity every cycle.
    always @(negedge clk) begin
        logic [13:0] got, exp;
        logic [3:0]  bus;
        string       tag;
        if (sb_exp.size() > 0) begin
            exp = sb_exp.pop_front();
            tag = sb_tag.pop_front();
            got = {halted, c_ir_load, c_pc_inc, c_pc_load, c_imm, c_a, c_b, c_a_out,
                   c_alu_out, c_alu_sub, c_flags_load, c_mar_load, c_mem_out, c_mem_we};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL %s cyc=%0d got=%014b want=%014b", tag, cyc, got, exp);
            end
            bus = {c_imm, c_a_out, c_alu_out, c_mem_out};
            n_vec++;
            if ($countones(bus) > 1 || (c_mem_out && c_mem_we)) begin
                n_err++;
                $display("FAIL bus_onehot_%s cyc=%0d got drivers=%04b we=%b want at most one",
                         tag, cyc, bus, c_mem_we);
            end
        end
    end

    initial begin
        logic [3:0] rop;
        logic       rz, rc;

        // Reset state.
        tick(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 14'h0, "reset0");
        tick(1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 14'h0, "reset_dominates");
        tick(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 14'h0, "fetch_idle");

        instr(4'h1, 1'b0, 1'b0, "lda");

        // Wait states in FETCH.
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 4'h2, 1'b0, 1'b0, 14'h0, "wait_rdy");
        instr(4'h2, 1'b0, 1'b0, "ldb");

        instr(4'h3, 1'b1, 1'b1, "add");
        instr(4'h4, 1'b0, 1'b0, "sub");
        instr(4'h0, 1'b0, 1'b0, "nop");
        instr(4'hA, 1'b1, 1'b1, "opA");
        instr(4'hE, 1'b1, 1'b1, "opE");
        instr(4'h7, 1'b0, 1'b0, "jmp");
        instr(4'h8, 1'b0, 1'b0, "jz_z0");
        instr(4'h8, 1'b1, 1'b0, "jz_z1");
        instr(4'h9, 1'b1, 1'b0, "jc_c0");
        instr(4'h9, 1'b0, 1'b1, "jc_c1");
        instr(4'h5, 1'b0, 1'b0, "ldm");
        instr(4'h6, 1'b0, 1'b0, "stm");
        tick(1'b0, 1'b0, 1'b1, 4'h6, 1'b0, 1'b0, 14'h0, "run_low_wait");

        // Random opcode stream (HLT excluded so the stream keeps running).
        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 14));
            rz  = 1'($urandom_range(0, 1));
            rc  = 1'($urandom_range(0, 1));
            instr(rop, rz, rc, "rand");
        end

        // Reset during EXEC2 of LDM.
        tick(1'b0, 1'b1, 1'b1, 4'h5, 1'b0, 1'b0, MIR | MPCI, "ldm_rst_fetch");
        tick(1'b0, 1'b0, 1'b0, 4'h5, 1'b0, 1'b0, 14'h0, "ldm_rst_decode");
        tick(1'b0, 1'b0, 1'b0, 4'h5, 1'b0, 1'b0, MIMM | MMAR, "ldm_rst_exec1");
        tick(1'b1, 1'b0, 1'b0, 4'h5, 1'b0, 1'b0, 14'h0, "ldm_rst_exec2");
        tick(1'b0, 1'b0, 1'b1, 4'h5, 1'b0, 1'b0, 14'h0, "after_rst_fetch");
        instr(4'h1, 1'b0, 1'b0, "lda_after_rst");

        // HLT parks until reset, ignoring run.
        instr(4'hF, 1'b0, 1'b0, "hlt");
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, MH, "halted");
        tick(1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 14'h0, "halt_reset");
        tick(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 14'h0, "post_halt_fetch");
        instr(4'h2, 1'b0, 1'b0, "ldb_after_halt");
        tick(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 14'h0, "tail");

        @(negedge clk);
        #1;
        if (sb_exp.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb_exp.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
